fifo_frame_writer: RTL and testbench

//  Write side of the frame FIFO drained by the VGA output reader. Takes a 720x576 pixel stream
//  and emits per frame: SYNC0 (0x8000_0000), SYNC1 (0x7FFF_FFFF), then PIX_COUNT payload words.

---
 rtl/fifo_frame_writer_pkg.sv | 26 ++
 rtl/fifo_frame_writer.sv | 102 ++++++++++
 tb/tb_fifo_frame_writer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_frame_writer_pkg.sv
// Shared video constants for the frame FIFO writer and reader: sync words,
// frame geometry and the writer state encoding.
package fifo_frame_writer_pkg;

    localparam int unsigned VID_H_ACTIVE  = 720;
    localparam int unsigned VID_V_ACTIVE  = 576;
    localparam int unsigned VID_PIX_COUNT = VID_H_ACTIVE * VID_V_ACTIVE;
    localparam int unsigned VID_CNT_W     = 19;

    localparam logic [31:0] VID_SYNC_WORD0 = 32'h8000_0000;
    localparam logic [31:0] VID_SYNC_WORD1 = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StPayload,
        StDrop
    } frame_state_e;

    // Clearing bit31 keeps SYNC_WORD0 out of the payload so the reader only locks on headers.
    function automatic logic [31:0] payload_word(input logic [31:0] pix);
        return {1'b0, pix[30:0]};
    endfunction

endpackage

// File: rtl/fifo_frame_writer.sv
// Write side of the frame FIFO: emits a two-word header then PIX_COUNT payload words per
// frame, dropping the remainder of a frame on FIFO full so the reader can re-sync.
module fifo_frame_writer
    import fifo_frame_writer_pkg::*;
#(
    parameter int unsigned PIX_COUNT  = VID_PIX_COUNT,
    parameter int unsigned CNT_W      = VID_CNT_W,
    parameter logic [31:0] SYNC_WORD0 = VID_SYNC_WORD0,
    parameter logic [31:0] SYNC_WORD1 = VID_SYNC_WORD1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [31:0] pix_data,
    input  logic        fifo_wr_full,
    output logic        fifo_wr_req,
    output logic [31:0] fifo_wr_data,
    output logic        frame_active,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frames_done
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_COUNT - 1);

    frame_state_e     state;
    logic [CNT_W-1:0] pix_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            pix_cnt      <= '0;
            fifo_wr_req  <= 1'b0;
            fifo_wr_data <= '0;
            frame_active <= 1'b0;
            overflow     <= 1'b0;
            short_frame  <= 1'b0;
            frames_done  <= '0;
        end else begin
            fifo_wr_req <= 1'b0;
            // frame_start overrides everything, including a coincident last pixel.
            if (frame_start) begin
                if (state == StPayload && pix_cnt != '0) begin
                    short_frame <= 1'b1;
                end
                state        <= StHdr0;
                pix_cnt      <= '0;
                frame_active <= 1'b1;
            end else begin
                case (state)
                    StHdr0: begin
                        if (pix_valid || fifo_wr_full) begin
                            overflow     <= 1'b1;
                            state        <= StDrop;
                            frame_active <= 1'b0;
                        end else begin
                            fifo_wr_req  <= 1'b1;
                            fifo_wr_data <= SYNC_WORD0;
                            state        <= StHdr1;
                        end
                    end
                    StHdr1: begin
                        if (pix_valid || fifo_wr_full) begin
                            overflow     <= 1'b1;
                            state        <= StDrop;
                            frame_active <= 1'b0;
                        end else begin
                            fifo_wr_req  <= 1'b1;
                            fifo_wr_data <= SYNC_WORD1;
                            state        <= StPayload;
                        end
                    end
                    StPayload: begin
                        if (pix_valid) begin
                            if (fifo_wr_full) begin
                                overflow     <= 1'b1;
                                state        <= StDrop;
                                frame_active <= 1'b0;
                            end else begin
                                fifo_wr_req  <= 1'b1;
                                fifo_wr_data <= payload_word(pix_data);
                                if (pix_cnt == LAST_PIX) begin
                                    pix_cnt      <= '0;
                                    frames_done  <= frames_done + 16'd1;
                                    state        <= StIdle;
                                    frame_active <= 1'b0;
                                end else begin
                                    pix_cnt <= pix_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        // StIdle and StDrop discard pixels until the next frame_start.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer with a shortened frame of 16 pixels.
module tb_fifo_frame_writer;

    localparam int unsigned P = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        fifo_wr_full;
    logic        fifo_wr_req;
    logic [31:0] fifo_wr_data;
    logic        frame_active;
    logic        overflow;
    logic        short_frame;
    logic [15:0] frames_done;

    int total = 0;
    int bad   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    fifo_frame_writer #(
        .PIX_COUNT (P),
        .CNT_W     (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .fifo_wr_full (fifo_wr_full),
        .fifo_wr_req  (fifo_wr_req),
        .fifo_wr_data (fifo_wr_data),
        .frame_active (frame_active),
        .overflow     (overflow),
        .short_frame  (short_frame),
        .frames_done  (frames_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (fifo_wr_req) got_q.push_back(fifo_wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_hdr();
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h7FFF_FFFF);
    endtask

    // Pulse frame_start, then let both header cycles pass before the first pixel.
    task automatic start_frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pixel(input logic [31:0] d);
        pix_valid = 1'b1;
        pix_data  = d;
        cyc();
        pix_valid = 1'b0;
        pix_data  = 32'hDEAD_BEEF;
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    32'(fifo_wr_req),  32'h0);
        chk({tag, "_data"},   fifo_wr_data,      32'h0);
        chk({tag, "_active"}, 32'(frame_active), 32'h0);
        chk({tag, "_ovf"},    32'(overflow),     32'h0);
        chk({tag, "_short"},  32'(short_frame),  32'h0);
        chk({tag, "_done"},   32'(frames_done),  32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        frame_start  = 1'b0;
        pix_valid    = 1'b0;
        pix_data     = 32'h0;
        fifo_wr_full = 1'b0;
        repeat (2) cyc();
        chk_all_zero("reset");
        reset = 1'b0;
        cyc();

        // Complete frame, including pixels whose bit31 must be cleared.
        start_frame();
        push_hdr();
        chk("f1_active", 32'(frame_active), 32'h1);
        for (int i = 0; i < int'(P); i++) begin
            if (i == 3) begin
                pixel(32'hFFFF_FFFF);
                exp_q.push_back(32'h7FFF_FFFF);
            end else if (i == 4) begin
                pixel(32'h8000_0000);
                exp_q.push_back(32'h0000_0000);
            end else begin
                pixel(32'(i));
                exp_q.push_back(32'(i));
            end
        end
        chk("f1_done", 32'(frames_done), 32'd1);
        chk("f1_ovf", 32'(overflow), 32'h0);
        chk("f1_inactive", 32'(frame_active), 32'h0);
        repeat (3) pixel(32'h55);
        check_writes("f1_writes");

        // FIFO full mid-payload: rest of frame dropped.
        start_frame();
        push_hdr();
        for (int i = 0; i < 5; i++) begin
            pixel(32'(100 + i));
            exp_q.push_back(32'(100 + i));
        end
        fifo_wr_full = 1'b1;
        pixel(32'd105);
        fifo_wr_full = 1'b0;
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_drop_inactive", 32'(frame_active), 32'h0);
        for (int i = 0; i < 4; i++) pixel(32'(200 + i));
        check_writes("ovf_writes");
        chk("ovf_done", 32'(frames_done), 32'd1);

        // FIFO full during HDR0: no header word written.
        frame_start = 1'b1;
        cyc();
        frame_start  = 1'b0;
        fifo_wr_full = 1'b1;
        cyc();
        fifo_wr_full = 1'b0;
        cyc();
        pixel(32'd1);
        chk("hdr_full_inactive", 32'(frame_active), 32'h0);
        check_writes("hdr_full_writes");

        start_frame();
        push_hdr();
        for (int i = 0; i < int'(P); i++) begin
            pixel(32'(300 + i));
            exp_q.push_back(32'(300 + i));
        end
        chk("recover_done", 32'(frames_done), 32'd2);
        check_writes("recover_writes");

        // Short frame: restart after 5 pixels.
        start_frame();
        push_hdr();
        for (int i = 0; i < 5; i++) begin
            pixel(32'(400 + i));
            exp_q.push_back(32'(400 + i));
        end
        chk("short_before", 32'(short_frame), 32'h0);
        start_frame();
        push_hdr();
        chk("short_set", 32'(short_frame), 32'h1);
        for (int i = 0; i < int'(P); i++) begin
            pixel(32'(500 + i));
            exp_q.push_back(32'(500 + i));
        end
        chk("short_done", 32'(frames_done), 32'd3);
        check_writes("short_writes");

        // Gapped pixel stream.
        start_frame();
        push_hdr();
        for (int i = 0; i < int'(P); i++) begin
            pixel(32'(600 + i));
            exp_q.push_back(32'(600 + i));
            cyc();
        end
        chk("gap_done", 32'(frames_done), 32'd4);
        check_writes("gap_writes");

        // Asynchronous reset mid-payload.
        start_frame();
        push_hdr();
        for (int i = 0; i < 8; i++) begin
            pixel(32'(700 + i));
            exp_q.push_back(32'(700 + i));
        end
        check_writes("pre_reset_writes");
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        cyc();
        reset = 1'b0;
        cyc();

        // frame_start coincident with last pixel: pixel lost, frame not counted.
        start_frame();
        push_hdr();
        for (int i = 0; i < int'(P) - 1; i++) begin
            pixel(32'(800 + i));
            exp_q.push_back(32'(800 + i));
        end
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = 32'h999;
        cyc();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        cyc();
        cyc();
        push_hdr();
        chk("coinc_short", 32'(short_frame), 32'h1);
        chk("coinc_done", 32'(frames_done), 32'd0);
        for (int i = 0; i < int'(P); i++) begin
            pixel(32'(900 + i));
            exp_q.push_back(32'(900 + i));
        end
        chk("coinc_next_done", 32'(frames_done), 32'd1);
        chk("coinc_ovf", 32'(overflow), 32'h0);
        check_writes("coinc_writes");

        // Pixel arriving during HDR1: only SYNC0 reaches the FIFO.
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        exp_q.push_back(32'h8000_0000);
        pixel(32'hABC);
        chk("hdr1_pix_ovf", 32'(overflow), 32'h1);
        chk("hdr1_pix_inactive", 32'(frame_active), 32'h0);
        pixel(32'd1);
        check_writes("hdr1_pix_writes");
        chk("hdr1_pix_done", 32'(frames_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
